id_control_stage: RTL and testbench

Parametrised decode-and-issue stage for the pipelined ARM-subset core. It sits between the IF/ID register and the EX stage. It decodes mode, op_code and S, evaluates the 4-bit condition field against the NZCV flags, and registers the resulting control word into the ID/EX boundary. Compared with the purely combinational control decoder it adds hazard bubbles, branch flush and an optional multi-cycle MUL sequencer that freezes upstream stages.

---
 rtl/ctrl_pkg.sv | 138 +++++++++++++
 rtl/cond_check.sv | 36 +++
 rtl/id_control_stage.sv | 150 +++++++++++++++
 tb/tb_id_control_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants, control-word layout and FSM states for the
// ID-stage control logic of the ARM-subset core.
package ctrl_pkg;

    // Instruction classes carried in the mode field
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_MUL = 2'b11;

    // Data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // EX commands
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // MUL wait counter width (covers MUL_LAT up to 15)
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE,
        MUL_WAIT
    } state_t;

    // Control word as registered into the ID/EX boundary; all-zero is a bubble
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r;
        logic       mem_w;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  is_mul;
    } dec_t;

    // Instruction-class decode; an undecodable instruction yields ctrl = '0
    function automatic dec_t decode(input logic [1:0] mode,
                                    input logic [3:0] op_code,
                                    input logic       s_in,
                                    input logic       mul_en);
        dec_t d;
        d = '0;
        case (mode)
            MODE_DP: begin
                d.ctrl.valid = 1'b1;
                d.ctrl.wb_en = 1'b1;
                d.ctrl.s     = s_in;
                case (op_code)
                    OP_MOV: d.ctrl.exe_cmd = EXE_MOV;
                    OP_MVN: d.ctrl.exe_cmd = EXE_MVN;
                    OP_ADD: d.ctrl.exe_cmd = EXE_ADD;
                    OP_ADC: d.ctrl.exe_cmd = EXE_ADC;
                    OP_SUB: d.ctrl.exe_cmd = EXE_SUB;
                    OP_SBC: d.ctrl.exe_cmd = EXE_SBC;
                    OP_AND: d.ctrl.exe_cmd = EXE_AND;
                    OP_ORR: d.ctrl.exe_cmd = EXE_ORR;
                    OP_EOR: d.ctrl.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        d.ctrl.exe_cmd = EXE_SUB;
                        d.ctrl.wb_en   = 1'b0;
                        d.ctrl.s       = 1'b1;
                    end
                    OP_TST: begin
                        d.ctrl.exe_cmd = EXE_AND;
                        d.ctrl.wb_en   = 1'b0;
                        d.ctrl.s       = 1'b1;
                    end
                    default: d.ctrl = '0;
                endcase
            end
            MODE_MEM: begin
                d.ctrl.valid   = 1'b1;
                d.ctrl.exe_cmd = EXE_ADD;
                d.ctrl.mem_r   = s_in;
                d.ctrl.mem_w   = ~s_in;
                d.ctrl.wb_en   = s_in;
            end
            MODE_BR: begin
                d.ctrl.valid   = 1'b1;
                d.ctrl.b       = 1'b1;
                d.ctrl.exe_cmd = EXE_NOP;
            end
            default: begin
                if (mul_en) begin
                    d.ctrl.valid   = 1'b1;
                    d.ctrl.wb_en   = 1'b1;
                    d.ctrl.s       = s_in;
                    d.ctrl.exe_cmd = EXE_MUL;
                    d.is_mul       = 1'b1;
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against the NZCV flags.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = status;

    // Map each condition code to its flag predicate; 1111 never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_control_stage.sv
// Decode-and-issue stage: decodes the ID instruction, applies the condition
// check, hazard bubbles and branch flush, sequences multi-cycle MUL issue and
// registers the resulting control word into the ID/EX boundary.
module id_control_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned EXE_CMD_W  = 4,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned MUL_EN     = 1,
    parameter int unsigned MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [3:0]            cond,
    input  logic [1:0]            mode,
    input  logic [3:0]            op_code,
    input  logic                  s_in,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [3:0]            status,
    input  logic                  hazard,
    input  logic                  flush,
    output logic                  busy,
    output logic                  ex_valid,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r,
    output logic                  ex_mem_w,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic [EXE_CMD_W-1:0]  ex_exe_cmd,
    output logic [REG_ADDR_W-1:0] ex_rd
);

    localparam logic             MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MUL_LAT - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    ctrl_t                   ex_q;
    logic [REG_ADDR_W-1:0]   ex_rd_q;
    logic [REG_ADDR_W-1:0]   mul_rd;
    logic                    mul_s;

    logic                    cond_pass;
    dec_t                    dec;
    logic                    issue_ok;
    logic                    mul_accept;
    ctrl_t                   mul_ctrl;

    cond_check u_cond_check (
        .cond   (cond),
        .status (status),
        .pass   (cond_pass)
    );

    // Decode the ID instruction and qualify it for issue
    always_comb begin
        dec        = decode(mode, op_code, s_in, MUL_EN != 0);
        issue_ok   = in_valid & dec.ctrl.valid & cond_pass;
        mul_accept = issue_ok & dec.is_mul & ~hazard & ~flush;
    end

    // Control word for the deferred MUL, rebuilt from fields latched at acceptance
    always_comb begin
        mul_ctrl         = '0;
        mul_ctrl.valid   = 1'b1;
        mul_ctrl.wb_en   = 1'b1;
        mul_ctrl.s       = mul_s;
        mul_ctrl.exe_cmd = EXE_MUL;
    end

    // Freeze request: held while a MUL is being accepted or still counting down
    always_comb begin
        busy = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:     busy = mul_accept & MUL_MULTI;
                MUL_WAIT: busy = ~flush & (cnt < CNT_LAST);
                default:  busy = 1'b0;
            endcase
        end
    end

    // Issue FSM and ID/EX register; priority flush > hazard > MUL wait > issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ex_q    <= '0;
            ex_rd_q <= '0;
            mul_rd  <= '0;
            mul_s   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (flush || hazard || !issue_ok) begin
                        ex_q    <= '0;
                        ex_rd_q <= '0;
                    end else if (dec.is_mul && MUL_MULTI) begin
                        // Upstream is frozen, but rd/S are latched so the
                        // deferred issue does not depend on ID holding them
                        ex_q    <= '0;
                        ex_rd_q <= '0;
                        state   <= MUL_WAIT;
                        cnt     <= CNT_W'(1);
                        mul_rd  <= rd;
                        mul_s   <= dec.ctrl.s;
                    end else begin
                        ex_q    <= dec.ctrl;
                        ex_rd_q <= rd;
                    end
                end
                MUL_WAIT: begin
                    if (flush) begin
                        ex_q    <= '0;
                        ex_rd_q <= '0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        ex_q    <= mul_ctrl;
                        ex_rd_q <= mul_rd;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        ex_q    <= '0;
                        ex_rd_q <= '0;
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    ex_q    <= '0;
                    ex_rd_q <= '0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_wb_en   = ex_q.wb_en;
    assign ex_mem_r   = ex_q.mem_r;
    assign ex_mem_w   = ex_q.mem_w;
    assign ex_b       = ex_q.b;
    assign ex_s       = ex_q.s;
    assign ex_exe_cmd = EXE_CMD_W'(ex_q.exe_cmd);
    assign ex_rd      = ex_rd_q;

endmodule

// File: tb/tb_id_control_stage.sv
// Self-checking bench for id_control_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural model of decode, condition
// evaluation and MUL timing. Two instances cover MUL_LAT = 3 and MUL_LAT = 1.
module tb_id_control_stage;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, s_in, hazard, flush;
    logic [3:0] cond, op_code, rd, status;
    logic [1:0] mode;

    logic       busy_o     [2];
    logic       ex_valid   [2];
    logic       ex_wb_en   [2];
    logic       ex_mem_r   [2];
    logic       ex_mem_w   [2];
    logic       ex_b       [2];
    logic       ex_s       [2];
    logic [3:0] ex_exe_cmd [2];
    logic [3:0] ex_rd      [2];

    id_control_stage #(.EXE_CMD_W(4), .REG_ADDR_W(4), .MUL_EN(1), .MUL_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cond(cond), .mode(mode),
        .op_code(op_code), .s_in(s_in), .rd(rd), .status(status), .hazard(hazard),
        .flush(flush), .busy(busy_o[0]), .ex_valid(ex_valid[0]), .ex_wb_en(ex_wb_en[0]),
        .ex_mem_r(ex_mem_r[0]), .ex_mem_w(ex_mem_w[0]), .ex_b(ex_b[0]), .ex_s(ex_s[0]),
        .ex_exe_cmd(ex_exe_cmd[0]), .ex_rd(ex_rd[0])
    );

    id_control_stage #(.EXE_CMD_W(4), .REG_ADDR_W(4), .MUL_EN(1), .MUL_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cond(cond), .mode(mode),
        .op_code(op_code), .s_in(s_in), .rd(rd), .status(status), .hazard(hazard),
        .flush(flush), .busy(busy_o[1]), .ex_valid(ex_valid[1]), .ex_wb_en(ex_wb_en[1]),
        .ex_mem_r(ex_mem_r[1]), .ex_mem_w(ex_mem_w[1]), .ex_b(ex_b[1]), .ex_s(ex_s[1]),
        .ex_exe_cmd(ex_exe_cmd[1]), .ex_rd(ex_rd[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         lat [2];
    int         cmd_of_op [16];
    bit         inflight [2];
    int         edges_left [2];
    logic [3:0] m_rd [2];
    logic       m_s [2];

    // ARM condition: bits [3:1] select a predicate, bit 0 inverts it
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] == 1'b0;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Expected issued word {valid,wb,mem_r,mem_w,b,s,cmd[3:0],rd[3:0]}; 0 = bubble
    function automatic logic [13:0] ref_word();
        int cmd = 0;
        bit wb = 0, mr = 0, mw = 0, br = 0, s = 0;
        bit flag_only;
        if (!in_valid || !cond_ok(cond, status)) return '0;
        case (mode)
            2'd0: begin
                cmd = cmd_of_op[op_code];
                if (cmd < 0) return '0;
                flag_only = (op_code == 4'd10) || (op_code == 4'd8);
                wb = !flag_only;
                s  = flag_only ? 1'b1 : s_in;
            end
            2'd1: begin cmd = 2; mr = s_in; mw = !s_in; wb = s_in; end
            2'd2: begin cmd = 0; br = 1; end
            default: begin cmd = 10; wb = 1; s = s_in; end
        endcase
        return {1'b1, wb, mr, mw, br, s, 4'(cmd), rd};
    endfunction

    function automatic logic [13:0] dut_word(input int i);
        return {ex_valid[i], ex_wb_en[i], ex_mem_r[i], ex_mem_w[i], ex_b[i], ex_s[i],
                ex_exe_cmd[i], ex_rd[i]};
    endfunction

    // One clock cycle: inputs were driven at the falling edge
    task automatic step();
        logic [13:0] w;
        logic [13:0] exp_next [2];
        bit          exp_busy [2];
        bit          is_mul;
        #1;
        w      = ref_word();
        is_mul = w[13] && (mode == 2'b11);
        for (int i = 0; i < 2; i++) begin
            exp_busy[i] = 0;
            exp_next[i] = '0;
            if (!rst_n) begin
                inflight[i] = 0;
            end else if (inflight[i]) begin
                exp_busy[i] = !flush && (edges_left[i] > 1);
                if (flush) inflight[i] = 0;
                else if (edges_left[i] == 1) begin
                    exp_next[i] = {1'b1, 1'b1, 3'b000, m_s[i], 4'b1010, m_rd[i]};
                    inflight[i] = 0;
                end else edges_left[i]--;
            end else if (flush || hazard || !w[13]) begin
                exp_next[i] = '0;
            end else if (is_mul && lat[i] > 1) begin
                exp_busy[i]   = 1;
                inflight[i]   = 1;
                edges_left[i] = lat[i] - 1;
                m_rd[i]       = rd;
                m_s[i]        = s_in;
            end else begin
                exp_next[i] = w;
            end
            check_eq($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(exp_busy[i]));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("ex%0d", i), 32'(dut_word(i)), 32'(exp_next[i]));
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] m,
                         input logic [3:0] op, input logic s, input logic [3:0] r,
                         input logic [3:0] st, input logic hz, input logic fl);
        in_valid = v; cond = c; mode = m; op_code = op; s_in = s; rd = r;
        status = st; hazard = hz; flush = fl;
        step();
    endtask

    localparam logic [3:0] AL = 4'b1110;

    initial begin
        lat[0] = 3;
        lat[1] = 1;
        for (int k = 0; k < 16; k++) cmd_of_op[k] = -1;
        cmd_of_op[13] = 1; cmd_of_op[15] = 9; cmd_of_op[4]  = 2; cmd_of_op[5]  = 3;
        cmd_of_op[2]  = 4; cmd_of_op[6]  = 5; cmd_of_op[0]  = 6; cmd_of_op[12] = 7;
        cmd_of_op[1]  = 8; cmd_of_op[10] = 4; cmd_of_op[8]  = 6;
        for (int i = 0; i < 2; i++) begin inflight[i] = 0; edges_left[i] = 0; end

        rst_n = 1'b0;
        @(negedge clk);
        drive(1, AL, 2'b00, 4'b0100, 1, 4'd5, 4'h0, 0, 0);
        drive(1, AL, 2'b11, 4'b0000, 1, 4'd5, 4'h0, 0, 0);
        check_eq("rst_ex", 32'(dut_word(0)), 32'h0);
        check_eq("rst_busy", 32'(busy_o[0]), 32'h0);
        rst_n = 1'b1;

        // ADD with S, rd=3
        drive(1, AL, 2'b00, 4'b0100, 1, 4'd3, 4'h0, 0, 0);
        check_eq("add_cmd", 32'(ex_exe_cmd[0]), 32'h2);
        check_eq("add_rd", 32'(ex_rd[0]), 32'h3);
        // CMP forces S, no writeback; STR writes memory only
        drive(1, AL, 2'b00, 4'b1010, 0, 4'd1, 4'h0, 0, 0);
        check_eq("cmp_s_wb", 32'({ex_s[0], ex_wb_en[0]}), 32'b10);
        drive(1, AL, 2'b01, 4'b0000, 0, 4'd2, 4'h0, 0, 0);
        check_eq("str_memw", 32'({ex_mem_w[0], ex_wb_en[0], ex_exe_cmd[0]}), 32'b10_0010);
        // EQ MOV: Z clear fails, Z set passes
        drive(1, 4'b0000, 2'b00, 4'b1101, 0, 4'd4, 4'b0000, 0, 0);
        check_eq("eq_fail", 32'(dut_word(0)), 32'h0);
        drive(1, 4'b0000, 2'b00, 4'b1101, 0, 4'd4, 4'b0100, 0, 0);
        check_eq("eq_pass", 32'({ex_exe_cmd[0], ex_wb_en[0]}), 32'b0001_1);
        // MUL held in ID while frozen, issues after the third edge
        drive(1, AL, 2'b11, 4'b0000, 1, 4'd7, 4'h0, 0, 0);
        drive(1, AL, 2'b11, 4'b0000, 1, 4'd7, 4'h0, 0, 0);
        drive(1, AL, 2'b11, 4'b0000, 1, 4'd7, 4'h0, 0, 0);
        check_eq("mul_issue", 32'({ex_exe_cmd[0], ex_wb_en[0], ex_rd[0]}), 32'b1010_1_0111);
        // MUL aborted by flush in the first wait cycle
        drive(1, AL, 2'b11, 4'b0000, 0, 4'd9, 4'h0, 0, 0);
        drive(1, AL, 2'b11, 4'b0000, 0, 4'd9, 4'h0, 0, 1);
        drive(1, AL, 2'b10, 4'b0000, 0, 4'd0, 4'h0, 0, 0);
        check_eq("flush_branch", 32'(ex_b[0]), 32'h1);
        drive(1, AL, 2'b00, 4'b0100, 0, 4'd1, 4'h0, 0, 0);
        // hazard for two cycles, then ADD, then reset mid-MUL
        drive(1, AL, 2'b00, 4'b0100, 0, 4'd6, 4'h0, 1, 0);
        drive(1, AL, 2'b00, 4'b0100, 0, 4'd6, 4'h0, 1, 0);
        drive(1, AL, 2'b00, 4'b0100, 0, 4'd6, 4'h0, 0, 0);
        drive(1, AL, 2'b11, 4'b0000, 0, 4'd8, 4'h0, 0, 0);
        rst_n = 1'b0;
        drive(1, AL, 2'b11, 4'b0000, 0, 4'd8, 4'h0, 0, 0);
        rst_n = 1'b1;
        drive(0, AL, 2'b00, 4'b0000, 0, 4'd0, 4'h0, 0, 0);
        drive(0, AL, 2'b00, 4'b0000, 0, 4'd0, 4'h0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            drive($urandom_range(0, 9) != 0,
                  ($urandom_range(0, 1) != 0) ? AL : 4'($urandom),
                  2'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 12) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
